// File: rtl/combo_sequencer.sv
// Multi-digit combination lock sequencer: LOCKED / OPEN / PROGRAM / LOCKOUT.
// Optional build macro AUTO_RELOCK_EN adds an idle auto-relock timer in OPEN.
module combo_sequencer #(
   parameter int DIGITS         = 3,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 50000000,
   parameter int OPEN_CYCLES    = 250000000
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      Enter,
   input  logic                      Change,
   input  logic [3:0]                X,
   output logic                      Open,
   output logic                      New,
   output logic                      Alarm,
   output logic [$clog2(DIGITS):0]   DigitIdx,
   output logic [3:0]                Fails
);

   localparam int IDX_W   = $clog2(DIGITS) + 1;
   localparam int SEL_W   = $clog2(DIGITS);
   localparam int MAX_CYC = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
   localparam logic [3:0]       MAX_FAILS = 4'(MAX_TRIES);
   localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef AUTO_RELOCK_EN
   localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
`endif

   localparam logic [1:0] ST_LOCKED  = 2'd0;
   localparam logic [1:0] ST_OPEN    = 2'd1;
   localparam logic [1:0] ST_PROGRAM = 2'd2;
   localparam logic [1:0] ST_LOCKOUT = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       fails_q, fails_d;
   logic             mism_q, mism_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [3:0]       combo_q [DIGITS];
   logic [3:0]       stage_q [DIGITS];
   logic             open_q, new_q, alarm_q;
   logic             stage_we, commit, digit_miss;
   logic [SEL_W-1:0] sel;

   function automatic logic [3:0] sat_inc(input logic [3:0] f);
      return (f >= MAX_FAILS) ? MAX_FAILS : f + 4'd1;
   endfunction

   assign sel        = idx_q[SEL_W-1:0];
   assign digit_miss = (X != combo_q[sel]);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      fails_d  = fails_q;
      mism_d   = mism_q;
      tmr_d    = tmr_q;
      stage_we = 1'b0;
      commit   = 1'b0;
      case (state_q)
         ST_LOCKED: begin
            if (Enter) begin
               if (idx_q == LAST_IDX) begin
                  idx_d  = '0;
                  mism_d = 1'b0;
                  if (!(mism_q || digit_miss)) begin
                     state_d = ST_OPEN;
                     fails_d = '0;
                     tmr_d   = '0;
                  end else begin
                     fails_d = sat_inc(fails_q);
                     if (fails_d == MAX_FAILS) begin
                        state_d = ST_LOCKOUT;
                        tmr_d   = LOCK_LOAD;
                     end
                  end
               end else begin
                  idx_d  = idx_q + 1'b1;
                  mism_d = mism_q | digit_miss;
               end
            end
         end
         ST_OPEN: begin
            // Change outranks Enter when both arrive together
            if (Change) begin
               state_d = ST_PROGRAM;
               idx_d   = '0;
            end else if (Enter) begin
               state_d = ST_LOCKED;
               idx_d   = '0;
            end
`ifdef AUTO_RELOCK_EN
            else if (tmr_q == OPEN_LAST) begin
               state_d = ST_LOCKED;
               idx_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
`endif
         end
         ST_PROGRAM: begin
            if (Change) begin
               state_d = ST_OPEN;
               idx_d   = '0;
               tmr_d   = '0;
            end else if (Enter) begin
               if (idx_q == LAST_IDX) begin
                  commit  = 1'b1;
                  state_d = ST_LOCKED;
                  idx_d   = '0;
               end else begin
                  stage_we = 1'b1;
                  idx_d    = idx_q + 1'b1;
               end
            end
         end
         ST_LOCKOUT: begin
            if (tmr_q == '0) begin
               state_d = ST_LOCKED;
               fails_d = '0;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = ST_LOCKED;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_LOCKED;
         idx_q   <= '0;
         fails_q <= '0;
         mism_q  <= 1'b0;
         tmr_q   <= '0;
         open_q  <= 1'b0;
         new_q   <= 1'b0;
         alarm_q <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            combo_q[i] <= '0;
            stage_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         fails_q <= fails_d;
         mism_q  <= mism_d;
         tmr_q   <= tmr_d;
         open_q  <= (state_d == ST_OPEN) || (state_d == ST_PROGRAM);
         new_q   <= (state_d == ST_PROGRAM);
         alarm_q <= (state_d == ST_LOCKOUT);
         if (stage_we)
            stage_q[sel] <= X;
         // Last digit comes straight from X so the whole combo swaps in one edge
         if (commit) begin
            for (int i = 0; i < DIGITS - 1; i++)
               combo_q[i] <= stage_q[i];
            combo_q[DIGITS-1] <= X;
         end
      end
   end

   assign Open     = open_q;
   assign New      = new_q;
   assign Alarm    = alarm_q;
   assign DigitIdx = idx_q;
   assign Fails    = fails_q;

endmodule

// File: tb/tb_combo_sequencer.sv
// Bench for combo_sequencer: directed steps plus random traffic against a queue-based model.
module tb_combo_sequencer;
   localparam int DIGITS = 3;
   localparam int MAX_TRIES = 3;
   localparam int LOCKOUT_CYCLES = 20;
   localparam int OPEN_CYCLES = 16;

   localparam int M_LOCKED  = 0;
   localparam int M_OPEN    = 1;
   localparam int M_PROGRAM = 2;
   localparam int M_LOCKOUT = 3;

   logic       clk;
   logic       rst;
   logic       enter;
   logic       change;
   logic [3:0] x;
   logic       open_o;
   logic       new_o;
   logic       alarm_o;
   logic [$clog2(DIGITS):0] idx_o;
   logic [3:0] fails_o;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   int         m_mode;
   logic [3:0] m_combo [DIGITS];
   logic [3:0] entry [$];
   int         m_fails;
   int         lock_left;
   int         idle;

   combo_sequencer #(
      .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES),
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .OPEN_CYCLES(OPEN_CYCLES)
   ) dut (
      .Clock(clk), .Reset(rst), .Enter(enter), .Change(change), .X(x),
      .Open(open_o), .New(new_o), .Alarm(alarm_o), .DigitIdx(idx_o), .Fails(fails_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_LOCKED;
      foreach (m_combo[i]) m_combo[i] = 4'h0;
      entry.delete();
      m_fails = 0;
      lock_left = 0;
      idle = 0;
   endtask

   task automatic model_step(input logic e, input logic c, input logic [3:0] xv);
      bit match;
      case (m_mode)
         M_LOCKED: if (e) begin
            entry.push_back(xv);
            if (entry.size() == DIGITS) begin
               match = 1'b1;
               foreach (m_combo[i]) if (entry[i] != m_combo[i]) match = 1'b0;
               entry.delete();
               if (match) begin
                  m_mode = M_OPEN; m_fails = 0; idle = 0;
               end else begin
                  if (m_fails < MAX_TRIES) m_fails++;
                  if (m_fails == MAX_TRIES) begin
                     m_mode = M_LOCKOUT; lock_left = LOCKOUT_CYCLES;
                  end
               end
            end
         end
         M_OPEN: begin
            if (c) begin
               m_mode = M_PROGRAM; entry.delete();
            end else if (e) begin
               m_mode = M_LOCKED; entry.delete();
            end else begin
`ifdef AUTO_RELOCK_EN
               idle++;
               if (idle == OPEN_CYCLES) m_mode = M_LOCKED;
`endif
            end
         end
         M_PROGRAM: begin
            if (c) begin
               m_mode = M_OPEN; entry.delete(); idle = 0;
            end else if (e) begin
               entry.push_back(xv);
               if (entry.size() == DIGITS) begin
                  foreach (m_combo[i]) m_combo[i] = entry[i];
                  entry.delete();
                  m_mode = M_LOCKED;
               end
            end
         end
         default: begin
            lock_left--;
            if (lock_left == 0) begin
               m_mode = M_LOCKED; m_fails = 0;
            end
         end
      endcase
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".open"},  32'(open_o),  32'(m_mode == M_OPEN || m_mode == M_PROGRAM));
      chk({tag, ".new"},   32'(new_o),   32'(m_mode == M_PROGRAM));
      chk({tag, ".alarm"}, 32'(alarm_o), 32'(m_mode == M_LOCKOUT));
      chk({tag, ".idx"},   32'(idx_o),   32'(entry.size()));
      chk({tag, ".fails"}, 32'(fails_o), 32'(m_fails));
   endtask

   task automatic step(input logic e, input logic c, input logic [3:0] xv, input string tag);
      @(negedge clk);
      enter = e; change = c; x = xv;
      @(posedge clk);
      #1;
      model_step(e, c, xv);
      check_all(tag);
      enter = 1'b0; change = 1'b0;
   endtask

   task automatic enter3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input string tag);
      step(1'b1, 1'b0, a, tag);
      step(1'b1, 1'b0, b, tag);
      step(1'b1, 1'b0, d, tag);
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      #2;
      rst = 1'b1; enter = 1'b0; change = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int alarm_cycles;
      logic e, c;
      logic [3:0] xv;

      rst = 1'b1; enter = 1'b0; change = 1'b0; x = 4'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Default combo 0,0,0 opens
      enter3(4'h0, 4'h0, 4'h0, "open000");
      chk("open000.open_const", 32'(open_o), 32'd1);

      // Program 5,A,3
      step(1'b0, 1'b1, 4'h0, "chg");
      chk("prog.new_const", 32'(new_o), 32'd1);
      enter3(4'h5, 4'hA, 4'h3, "prog5a3");
      chk("prog5a3.locked_const", 32'(open_o), 32'd0);
      enter3(4'h5, 4'hA, 4'h3, "open5a3");
      chk("open5a3.open_const", 32'(open_o), 32'd1);
      step(1'b1, 1'b0, 4'h0, "relock");
      enter3(4'h0, 4'h0, 4'h0, "bad000");
      chk("bad000.fails_const", 32'(fails_o), 32'd1);

      // Clear fails, then three bad entries into lockout
      enter3(4'h5, 4'hA, 4'h3, "open_clear");
      step(1'b1, 1'b0, 4'h0, "relock2");
      enter3(4'h5, 4'hB, 4'h3, "bad1");
      enter3(4'h5, 4'hB, 4'h3, "bad2");
      enter3(4'h5, 4'hB, 4'h3, "bad3");
      chk("lockout.alarm_const", 32'(alarm_o), 32'd1);
      alarm_cycles = 1;
      for (int k = 0; k < 25; k++) begin
         step((k < 18) ? 1'(k % 2) : 1'b0, 1'b0, 4'h5, "lockout");
         if (alarm_o) alarm_cycles++;
      end
      chk("lockout.duration", 32'(alarm_cycles), 32'(LOCKOUT_CYCLES));
      chk("lockout.fails_after", 32'(fails_o), 32'd0);
      enter3(4'h5, 4'hA, 4'h3, "open_after_lockout");
      chk("open_after_lockout.const", 32'(open_o), 32'd1);

      // Abort programming keeps the old combo
      step(1'b0, 1'b1, 4'h0, "chg2");
      step(1'b1, 1'b0, 4'h7, "p7a");
      step(1'b1, 1'b0, 4'h7, "p7b");
      step(1'b0, 1'b1, 4'h0, "abort");
      chk("abort.new_const", 32'(new_o), 32'd0);
      step(1'b1, 1'b0, 4'h0, "relock3");
      enter3(4'h5, 4'hA, 4'h3, "old_combo");
      chk("old_combo.open_const", 32'(open_o), 32'd1);
      step(1'b1, 1'b1, 4'h9, "enter_and_change");
      chk("enter_and_change.new_const", 32'(new_o), 32'd1);

      // Async reset mid-PROGRAM, then mid-LOCKOUT
      step(1'b1, 1'b0, 4'h4, "p4");
      async_reset("arst_prog");
      enter3(4'h0, 4'h0, 4'h0, "zero_after_rst");
      step(1'b0, 1'b1, 4'h0, "chg3");
      enter3(4'h1, 4'h2, 4'h3, "prog123");
      enter3(4'h0, 4'h0, 4'h0, "bad_a");
      enter3(4'h0, 4'h0, 4'h0, "bad_b");
      enter3(4'h0, 4'h0, 4'h0, "bad_c");
      step(1'b0, 1'b0, 4'h0, "in_lockout");
      async_reset("arst_lockout");
      chk("arst_lockout.alarm_const", 32'(alarm_o), 32'd0);
      enter3(4'h0, 4'h0, 4'h0, "zero_after_rst2");

`ifdef AUTO_RELOCK_EN
      begin
         int open_cycles;
         open_cycles = 1;
         for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b0, 4'h0, "idle");
            if (open_o) open_cycles++;
         end
         chk("auto_relock.duration", 32'(open_cycles), 32'(OPEN_CYCLES));
         enter3(4'h0, 4'h0, 4'h0, "reopen");
         repeat (9) step(1'b0, 1'b0, 4'h0, "idle_pre");
         step(1'b0, 1'b1, 4'h0, "chg_at_10");
         step(1'b0, 1'b1, 4'h0, "abort_at_11");
         repeat (20) step(1'b0, 1'b0, 4'h0, "idle_post");
      end
`endif

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         e  = ($urandom_range(0, 9) < 4);
         c  = ($urandom_range(0, 19) == 0);
         xv = 4'($urandom_range(0, 3));
         step(e, c, xv, "rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
